// File: rtl/parallel_to_serial_if.sv
// Handshake and serial-output bundle for parallel_to_serial.
// The master modport drives words in; the slave modport is the serialiser side.
interface parallel_to_serial_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             serial_out;
    logic             frame_out;
    logic             done_pulse;

    modport master (
        output data_in,
        output load_valid,
        input  load_ready,
        input  serial_out,
        input  frame_out,
        input  done_pulse
    );

    modport slave (
        input  data_in,
        input  load_valid,
        output load_ready,
        output serial_out,
        output frame_out,
        output done_pulse
    );
endinterface

// File: rtl/parallel_to_serial.sv
// Purpose: serialises one WIDTH-bit word per frame, each bit held BIT_CYCLES cycles; optional even parity via PARITY_BIT_EN.
// Latency: first bit in the cycle after accept, done_pulse N*BIT_CYCLES+1 cycles after accept.
// Backpressure: load_ready only in IDLE; load_valid/data_in ignored while shifting, no queuing.
module parallel_to_serial #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 1,
    parameter int MSB_FIRST  = 1
) (
    input logic                 clock_pos,
    input logic                 reset_pos,
    parallel_to_serial_if.slave bus
);
`ifdef PARITY_BIT_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif
    localparam int CW = $clog2(N);
    localparam int PW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic [PW-1:0]    per_cnt;
`ifdef PARITY_BIT_EN
    logic             parity;
`endif

    function automatic logic head(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    // Shift so the next bit to send always sits at head().
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    always_ff @(posedge clock_pos) begin
        if (reset_pos) begin
            state          <= IDLE;
            shreg          <= '0;
            bit_cnt        <= '0;
            per_cnt        <= '0;
            bus.serial_out <= 1'b0;
            bus.frame_out  <= 1'b0;
            bus.done_pulse <= 1'b0;
            bus.load_ready <= 1'b1;
`ifdef PARITY_BIT_EN
            parity         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bus.done_pulse <= 1'b0;
                    bus.serial_out <= 1'b0;
                    bus.frame_out  <= 1'b0;
                    bus.load_ready <= 1'b1;
                    if (bus.load_valid) begin
                        state          <= SHIFT;
                        bus.load_ready <= 1'b0;
                        bus.frame_out  <= 1'b1;
                        bus.serial_out <= head(bus.data_in);
                        shreg          <= advance(bus.data_in);
                        bit_cnt        <= '0;
                        per_cnt        <= '0;
`ifdef PARITY_BIT_EN
                        parity         <= ^bus.data_in;
`endif
                    end
                end
                SHIFT: begin
                    if (per_cnt == PW'(BIT_CYCLES - 1)) begin
                        per_cnt <= '0;
                        if (bit_cnt == CW'(N - 1)) begin
                            state          <= IDLE;
                            bit_cnt        <= '0;
                            bus.serial_out <= 1'b0;
                            bus.frame_out  <= 1'b0;
                            bus.done_pulse <= 1'b1;
                            bus.load_ready <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                            shreg   <= advance(shreg);
`ifdef PARITY_BIT_EN
                            // Parity follows the last data bit regardless of bit order.
                            bus.serial_out <= (bit_cnt == CW'(WIDTH - 1)) ? parity : head(shreg);
`else
                            bus.serial_out <= head(shreg);
`endif
                        end
                    end else begin
                        per_cnt <= per_cnt + PW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
